ibex_irq_sched: RTL and testbench

// Interrupt scheduler between the raw irq inputs and ibex_controller. It does four jobs:
//   - Latches edge-type and NMI sources.
//   - Applies mstatus.MIE / mie masking.
//   - Picks one winner by priority and presents it as a stable (req, cause) pair.
//   - Retires the winner on controller ack.
// It feeds the mip view to the CSR block and the cause to mcause via exc_cause_e encoding.
//

---
 rtl/ibex_irq_sched.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_ibex_irq_sched.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_irq_sched.sv
// ---------------------------------------------------------------------------
// ibex_irq_sched
//
// Interrupt scheduler that sits between the raw irq inputs and the core
// controller. Its jobs:
//   - Register the raw inputs.
//   - Latch rising-edge fast sources and the NMI.
//   - Apply mstatus.MIE / mie masking.
//   - Pick one winner by priority.
//   - Hold the winner as a stable (req, cause) pair until the controller acks.
//   - After an ack, sit in HOLD for HoldCycles cycles before arbitrating again.
//
// Pending/enable vectors use the irqs_t layout: {sw, timer, ext, fast[14:0]}.
//
// Parameters:
//   FastEdgeMask  per-bit; 1 = irq_fast_i[n] is rising-edge latched, 0 = level
//   HoldCycles    cycles spent in HOLD after an ack (legal 1..3)
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   irq_software_i        machine software irq (level)
//   irq_timer_i           machine timer irq (level)
//   irq_external_i        machine external irq (level)
//   irq_fast_i[14:0]      fast irqs, level or edge per FastEdgeMask
//   irq_nm_i              non-maskable irq, rising-edge latched
//   csr_mstatus_mie_i     global machine irq enable
//   csr_mie_i[17:0]       per-source enables (irqs_t layout)
//   debug_mode_i          blocks every source, including the NMI
//   irq_ack_i             controller accepted irq_cause_o (honoured only in REQ)
//   irq_req_o             registered request to the controller
//   irq_cause_o[5:0]      registered exc_cause_e of the winner, stable in REQ
//   irq_pending_o         any enabled pending irq or NMI (WFI wakeup)
//   csr_mip_o[17:0]       pending vector (irqs_t layout)
//
// Configuration macro:
//   IBEX_IRQ_FAST_RR_EN   when defined, the fast group is served round-robin.
//                         A 4-bit pointer moves to (acked fast id + 1) mod 15.
//                         When undefined, the lowest fast index wins and no
//                         pointer flops exist.
// ---------------------------------------------------------------------------
module ibex_irq_sched #(
    parameter logic [14:0] FastEdgeMask = 15'h0000,
    parameter int unsigned HoldCycles   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        irq_software_i,
    input  logic        irq_timer_i,
    input  logic        irq_external_i,
    input  logic [14:0] irq_fast_i,
    input  logic        irq_nm_i,
    input  logic        csr_mstatus_mie_i,
    input  logic [17:0] csr_mie_i,
    input  logic        debug_mode_i,
    input  logic        irq_ack_i,
    output logic        irq_req_o,
    output logic [5:0]  irq_cause_o,
    output logic        irq_pending_o,
    output logic [17:0] csr_mip_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

    localparam logic [1:0] HOLD_LAST = 2'(HoldCycles - 32'd1);

    localparam logic [5:0] CAUSE_NMI  = 6'h3F;
    localparam logic [5:0] CAUSE_FAST = 6'h30;
    localparam logic [5:0] CAUSE_EXT  = 6'h2B;
    localparam logic [5:0] CAUSE_SW   = 6'h23;
    localparam logic [5:0] CAUSE_TMR  = 6'h27;

    // Round-robin search over the fast group starting at ptr.
    // Returns {found, id}.
    function automatic logic [4:0] rr_pick(input logic [15:0] elig, input logic [3:0] ptr);
        logic [4:0] idx;
        logic       found;
        logic [3:0] id;
        found = 1'b0;
        id    = 4'd0;
        for (int i = 0; i < 15; i++) begin
            idx = {1'b0, ptr} + 5'(i);
            if (idx >= 5'd15) begin
                idx = idx - 5'd15;
            end else begin
                idx = idx;
            end
            if (!found && elig[idx[3:0]]) begin
                found = 1'b1;
                id    = idx[3:0];
            end
        end
        return {found, id};
    endfunction

    // Registered copies of the raw inputs plus edge history.
    logic [17:0] r_irq_q;
    logic [14:0] r_fast_prev;
    logic        r_nmi_q;
    logic        r_nmi_prev;
    logic [14:0] r_fast_latch;
    logic        r_nmi_latch;

    state_e      r_state;
    state_e      w_state_d;
    logic [1:0]  r_hold_cnt;
    logic [1:0]  w_hold_d;
    logic        r_req;
    logic        w_req_d;
    logic [5:0]  r_cause;
    logic [5:0]  w_cause_d;
    logic        w_ack_fire;

    logic [14:0] w_fast_edge;
    logic        w_nmi_edge;
    logic [17:0] w_mip;
    logic        w_nmi_pend;
    logic [17:0] w_elig;
    logic        w_nmi_elig;
    logic        w_any;
    logic [4:0]  w_rr;
    logic        w_fast_found;
    logic [3:0]  w_fast_id;
    logic [5:0]  w_win_cause;
    logic        w_clr_nmi;
    logic        w_ack_fast;
    logic [14:0] w_fast_clr;
    logic [3:0]  w_rr_ptr;

    // Edges are seen one cycle after the input rises; the latch then holds
    // them. OR-ing the live edge into the pending view keeps mip at a single
    // cycle of latency for edge sources as well as level sources.
    assign w_fast_edge = r_irq_q[14:0] & ~r_fast_prev;
    assign w_nmi_edge  = r_nmi_q & ~r_nmi_prev;
    assign w_nmi_pend  = r_nmi_latch | w_nmi_edge;

    assign w_mip = {r_irq_q[17:15],
                    (FastEdgeMask & (r_fast_latch | w_fast_edge)) |
                    (~FastEdgeMask & r_irq_q[14:0])};

    assign w_elig     = debug_mode_i ? 18'h00000 : (w_mip & csr_mie_i & {18{csr_mstatus_mie_i}});
    assign w_nmi_elig = ~debug_mode_i & w_nmi_pend;
    assign w_any      = w_nmi_elig | (|w_elig);

`ifdef IBEX_IRQ_FAST_RR_EN
    logic [3:0] r_rr_ptr;
    assign w_rr_ptr = r_rr_ptr;

    // Round-robin pointer: moves just past the fast source that was acked.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_ptr <= 4'd0;
        end else if (w_ack_fast) begin
            r_rr_ptr <= (r_cause[3:0] == 4'd14) ? 4'd0 : (r_cause[3:0] + 4'd1);
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end
`else
    assign w_rr_ptr = 4'd0;
`endif

    assign w_rr         = rr_pick({1'b0, w_elig[14:0]}, w_rr_ptr);
    assign w_fast_found = w_rr[4];
    assign w_fast_id    = w_rr[3:0];

    // Fixed priority: NMI > fast group > ext > sw > timer.
    always_comb begin
        w_win_cause = 6'h00;
        if (w_nmi_elig) begin
            w_win_cause = CAUSE_NMI;
        end else if (w_fast_found) begin
            w_win_cause = CAUSE_FAST + {2'b00, w_fast_id};
        end else if (w_elig[15]) begin
            w_win_cause = CAUSE_EXT;
        end else if (w_elig[17]) begin
            w_win_cause = CAUSE_SW;
        end else if (w_elig[16]) begin
            w_win_cause = CAUSE_TMR;
        end else begin
            w_win_cause = 6'h00;
        end
    end

    // Next-state, request and cause logic for the IDLE/REQ/HOLD sequencer.
    always_comb begin
        w_state_d  = r_state;
        w_hold_d   = r_hold_cnt;
        w_req_d    = r_req;
        w_cause_d  = r_cause;
        w_ack_fire = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_d = ST_REQ;
                    w_req_d   = 1'b1;
                    w_cause_d = w_win_cause;
                end else begin
                    w_req_d   = 1'b0;
                end
            end
            ST_REQ: begin
                // The cause is frozen here; the ack is honoured even if
                // the source has since been withdrawn or masked.
                if (irq_ack_i) begin
                    w_state_d  = ST_HOLD;
                    w_req_d    = 1'b0;
                    w_hold_d   = 2'd0;
                    w_ack_fire = 1'b1;
                end else if (debug_mode_i) begin
                    w_state_d = ST_IDLE;
                    w_req_d   = 1'b0;
                end else begin
                    w_req_d   = 1'b1;
                end
            end
            ST_HOLD: begin
                w_req_d = 1'b0;
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_d = ST_IDLE;
                end else begin
                    w_hold_d = r_hold_cnt + 2'd1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_req_d   = 1'b0;
                w_hold_d  = 2'd0;
            end
        endcase
    end

    // The acked cause identifies which latch to retire; level bits have no
    // latch, so clearing them is a no-op through FastEdgeMask.
    assign w_clr_nmi  = w_ack_fire && (r_cause == CAUSE_NMI);
    assign w_ack_fast = w_ack_fire && (r_cause[5:4] == 2'b11) && (r_cause[3:0] != 4'hF);
    assign w_fast_clr = w_ack_fast ? (15'h0001 << r_cause[3:0]) : 15'h0000;

    // Input registers, edge history and edge/NMI latches. A new edge in the
    // same cycle as the ack keeps its latch set.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_irq_q      <= 18'h00000;
            r_fast_prev  <= 15'h0000;
            r_nmi_q      <= 1'b0;
            r_nmi_prev   <= 1'b0;
            r_fast_latch <= 15'h0000;
            r_nmi_latch  <= 1'b0;
        end else begin
            r_irq_q      <= {irq_software_i, irq_timer_i, irq_external_i, irq_fast_i};
            r_fast_prev  <= r_irq_q[14:0];
            r_nmi_q      <= irq_nm_i;
            r_nmi_prev   <= r_nmi_q;
            r_fast_latch <= ((r_fast_latch & ~w_fast_clr) | w_fast_edge) & FastEdgeMask;
            r_nmi_latch  <= (r_nmi_latch & ~w_clr_nmi) | w_nmi_edge;
        end
    end

    // Sequencer state, hold counter and registered request/cause outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 2'd0;
            r_req      <= 1'b0;
            r_cause    <= 6'h00;
        end else begin
            r_state    <= w_state_d;
            r_hold_cnt <= w_hold_d;
            r_req      <= w_req_d;
            r_cause    <= w_cause_d;
        end
    end

    assign irq_req_o     = r_req;
    assign irq_cause_o   = r_cause;
    assign csr_mip_o     = w_mip;
    assign irq_pending_o = (|(w_mip & csr_mie_i)) | w_nmi_pend;

endmodule

// File: tb/tb_ibex_irq_sched.sv
module tb_ibex_irq_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sw, tmr, ext;
    logic [14:0] fast;
    logic        nm;
    logic        mie_g;
    logic [17:0] mie;
    logic        dbg;
    logic        ack;
    logic        req;
    logic [5:0]  cause;
    logic        pending;
    logic [17:0] mip;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [5:0]  exp_q[$];
    logic [5:0]  exp_c;
    bit          got;

    always #5 clk = ~clk;

    ibex_irq_sched #(
        .FastEdgeMask(15'h0001),
        .HoldCycles  (1)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .irq_software_i   (sw),
        .irq_timer_i      (tmr),
        .irq_external_i   (ext),
        .irq_fast_i       (fast),
        .irq_nm_i         (nm),
        .csr_mstatus_mie_i(mie_g),
        .csr_mie_i        (mie),
        .debug_mode_i     (dbg),
        .irq_ack_i        (ack),
        .irq_req_o        (req),
        .irq_cause_o      (cause),
        .irq_pending_o    (pending),
        .csr_mip_o        (mip)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_req(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (req === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok && req === 1'b1) ok = 1'b1;
    endtask

    task automatic pop_exp(output logic [5:0] e);
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = 6'h00;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sw = 1'b0; tmr = 1'b0; ext = 1'b0; fast = 15'h0000; nm = 1'b0;
        mie_g = 1'b1; mie = 18'h3FFFF; dbg = 1'b0; ack = 1'b0;
        tick(); tick();
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", req); end
        n_cmp++; if (cause !== 6'h00) begin n_bad++; $display("FAIL reset_cause: got %h want 00", cause); end
        n_cmp++; if (pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending: got %b want 0", pending); end
        n_cmp++; if (mip !== 18'h00000) begin n_bad++; $display("FAIL reset_mip: got %h want 00000", mip); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_nmi();
        nm = 1'b1;
        exp_q.push_back(6'h3F);
        tick();
        n_cmp++; if (req !== 1'b0 || pending !== 1'b1) begin
            n_bad++; $display("FAIL nmi_plus1: req=%b pending=%b want req=0 pending=1", req, pending); end
        nm = 1'b0;
        tick();
        pop_exp(exp_c);
        n_cmp++; if (req !== 1'b1 || cause !== exp_c) begin
            n_bad++; $display("FAIL nmi_plus2: req=%b cause=%h want req=1 cause=%h", req, cause, exp_c); end
        do_ack();
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL nmi_hold: req=%b want 0", req); end
        tick(); tick();
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL nmi_idle: req=%b want 0", req); end
    endtask

    task automatic test_level();
        tmr = 1'b1; ext = 1'b1;
        exp_q.push_back(6'h2B);
        tick();
        n_cmp++; if (mip !== 18'h18000 || req !== 1'b0) begin
            n_bad++; $display("FAIL level_mip: mip=%h req=%b want mip=18000 req=0", mip, req); end
        wait_req(8, got);
        pop_exp(exp_c);
        n_cmp++; if (!got || cause !== exp_c) begin
            n_bad++; $display("FAIL level_grant1: req=%b cause=%h want req=1 cause=%h", req, cause, exp_c); end
        do_ack();
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL level_hold: req=%b want 0", req); end
        exp_q.push_back(6'h2B);
        wait_req(8, got);
        pop_exp(exp_c);
        n_cmp++; if (!got || cause !== exp_c) begin
            n_bad++; $display("FAIL level_grant2: req=%b cause=%h want req=1 cause=%h", req, cause, exp_c); end
        ack = 1'b1; tmr = 1'b0; ext = 1'b0;
        tick();
        ack = 1'b0;
        tick(); tick();
        n_cmp++; if (req !== 1'b0 || mip !== 18'h00000) begin
            n_bad++; $display("FAIL level_drain: req=%b mip=%h want req=0 mip=00000", req, mip); end
    endtask

    task automatic test_edge_masked();
        mie_g = 1'b0;
        fast[0] = 1'b1;
        tick();
        fast[0] = 1'b0;
        tick(); tick();
        n_cmp++; if (mip !== 18'h00001 || req !== 1'b0 || pending !== 1'b1) begin
            n_bad++; $display("FAIL edge_latched: mip=%h req=%b pending=%b want mip=00001 req=0 pending=1", mip, req, pending); end
        mie_g = 1'b1;
        exp_q.push_back(6'h30);
        wait_req(8, got);
        pop_exp(exp_c);
        n_cmp++; if (!got || cause !== exp_c) begin
            n_bad++; $display("FAIL edge_grant: req=%b cause=%h want req=1 cause=%h", req, cause, exp_c); end
        do_ack();
        n_cmp++; if (mip !== 18'h00000) begin n_bad++; $display("FAIL edge_cleared: mip=%h want 00000", mip); end
        tick(); tick();
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL edge_idle: req=%b want 0", req); end
    endtask

    task automatic test_no_preempt();
        tmr = 1'b1;
        exp_q.push_back(6'h27);
        wait_req(8, got);
        pop_exp(exp_c);
        n_cmp++; if (!got || cause !== exp_c) begin
            n_bad++; $display("FAIL nopre_grant: req=%b cause=%h want req=1 cause=%h", req, cause, exp_c); end
        tmr = 1'b0; nm = 1'b1;
        exp_q.push_back(6'h3F);
        tick();
        nm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (req !== 1'b1 || cause !== 6'h27) begin
                n_bad++; $display("FAIL nopre_stable%0d: req=%b cause=%h want req=1 cause=27", i, req, cause); end
            tick();
        end
        do_ack();
        wait_req(8, got);
        pop_exp(exp_c);
        n_cmp++; if (!got || cause !== exp_c) begin
            n_bad++; $display("FAIL nopre_nmi: req=%b cause=%h want req=1 cause=%h", req, cause, exp_c); end
        do_ack();
        tick(); tick();
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL nopre_idle: req=%b want 0", req); end
    endtask

    task automatic test_debug();
        nm = 1'b1;
        exp_q.push_back(6'h3F);
        tick();
        nm = 1'b0;
        wait_req(8, got);
        pop_exp(exp_c);
        n_cmp++; if (!got || cause !== exp_c) begin
            n_bad++; $display("FAIL dbg_grant1: req=%b cause=%h want req=1 cause=%h", req, cause, exp_c); end
        dbg = 1'b1;
        tick();
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL dbg_drop: req=%b want 0", req); end
        tick(); tick();
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL dbg_blocked: req=%b want 0", req); end
        dbg = 1'b0;
        exp_q.push_back(6'h3F);
        wait_req(8, got);
        pop_exp(exp_c);
        n_cmp++; if (!got || cause !== exp_c) begin
            n_bad++; $display("FAIL dbg_grant2: req=%b cause=%h want req=1 cause=%h", req, cause, exp_c); end
        do_ack();
        tick(); tick();
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL dbg_idle: req=%b want 0", req); end
    endtask

    task automatic test_fast_rr();
        fast[2] = 1'b1; fast[5] = 1'b1;
`ifdef IBEX_IRQ_FAST_RR_EN
        exp_q.push_back(6'h32); exp_q.push_back(6'h35); exp_q.push_back(6'h32);
`else
        exp_q.push_back(6'h32); exp_q.push_back(6'h32); exp_q.push_back(6'h32);
`endif
        for (int k = 0; k < 3; k++) begin
            wait_req(8, got);
            pop_exp(exp_c);
            n_cmp++; if (!got || cause !== exp_c) begin
                n_bad++; $display("FAIL rr_grant%0d: req=%b cause=%h want req=1 cause=%h", k, req, cause, exp_c); end
            if (k == 2) begin
                fast[2] = 1'b0; fast[5] = 1'b0;
            end
            do_ack();
        end
        tick(); tick();
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL rr_idle: req=%b want 0", req); end
    endtask

    task automatic test_reset_mid();
        nm = 1'b1;
        exp_q.push_back(6'h3F);
        tick();
        nm = 1'b0;
        wait_req(8, got);
        pop_exp(exp_c);
        n_cmp++; if (!got || cause !== exp_c) begin
            n_bad++; $display("FAIL rmid_grant: req=%b cause=%h want req=1 cause=%h", req, cause, exp_c); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (req !== 1'b0 || cause !== 6'h00) begin
            n_bad++; $display("FAIL rmid_async: req=%b cause=%h want req=0 cause=00", req, cause); end
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        n_cmp++; if (req !== 1'b0 || pending !== 1'b0) begin
            n_bad++; $display("FAIL rmid_cleared: req=%b pending=%b want req=0 pending=0", req, pending); end
    endtask

    initial begin
        test_reset();
        test_nmi();
        test_level();
        test_edge_masked();
        test_no_preempt();
        test_debug();
        test_fast_rr();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
